ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_sync_edge.sv | 31 +++
 rtl/ps2_host_tx.sv | 218 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 types and command bytes for the host transmit and scan-code receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    WAIT_DEV,
    DATA,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_BREAK        = 8'hF0;

  // Value of bit_cnt when the parity and stop bits are placed on the wire.
  localparam logic [3:0] PS2_PARITY_CNT = 4'd8;
  localparam logic [3:0] PS2_STOP_CNT   = 4'd9;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a PS/2 pad plus falling-edge detect; no backpressure.
// Latency: sync_o follows the pad after 2 clk; fall_o is high for the cycle sync_o first reads 0.
module ps2_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic pad_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle PS/2 lines float high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= pad_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain clk/data enables; tx_ready gates new requests.
// Optional one-shot resend after a missing ack when PS2_TX_RESEND_EN is defined.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50000000,
  parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 1000000 * 120,
  parameter int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000 * 15
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  ps2_tx_state_e state_q, state_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          parity_q, parity_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          ok_q, ok_d;
  logic          idle_seen_q, idle_seen_d;
`ifdef PS2_TX_RESEND_EN
  logic          retry_q, retry_d;
`endif

  logic clk_s, clk_fall, dat_s;
  logic timed;

  ps2_sync_edge u_clk_sync (
    .clk    (clk),
    .resetn (resetn),
    .pad_i  (ps2_clk_in),
    .sync_o (clk_s),
    .fall_o (clk_fall)
  );

  ps2_sync_edge u_dat_sync (
    .clk    (clk),
    .resetn (resetn),
    .pad_i  (ps2_dat_in),
    .sync_o (dat_s),
    .fall_o ()
  );

  assign timed = (state_q == WAIT_DEV) || (state_q == DATA) || (state_q == ACK);

  always_comb begin
    state_d     = state_q;
    inh_cnt_d   = inh_cnt_q;
    to_cnt_d    = to_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    byte_d      = byte_q;
    parity_d    = parity_q;
    clk_oe_d    = clk_oe_q;
    dat_oe_d    = dat_oe_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    ok_d        = ok_q;
    idle_seen_d = idle_seen_q;
`ifdef PS2_TX_RESEND_EN
    retry_d     = retry_q;
`endif

    if (timed) begin
      to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
      if (clk_fall) begin
        to_cnt_d = '0;
      end
    end

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          byte_d    = tx_data;
          parity_d  = ~^tx_data;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = INHIBIT;
`ifdef PS2_TX_RESEND_EN
          retry_d   = 1'b0;
`endif
        end
      end
      INHIBIT: begin
        if (inh_cnt_q >= INH_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          to_cnt_d = '0;
          state_d  = WAIT_DEV;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      WAIT_DEV: begin
        if (clk_fall) begin
          dat_oe_d  = ~byte_q[0];
          bit_cnt_d = 4'd1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == PS2_STOP_CNT) begin
            dat_oe_d = 1'b0;
            state_d  = ACK;
          end else if (bit_cnt_q == PS2_PARITY_CNT) begin
            dat_oe_d = ~parity_q;
          end else begin
            dat_oe_d = ~byte_q[bit_cnt_q[2:0]];
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          ok_d        = ~dat_s;
          idle_seen_d = 1'b0;
          state_d     = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          idle_seen_d = 1'b1;
          if (idle_seen_q) begin
            idle_seen_d = 1'b0;
            if (ok_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
`ifdef PS2_TX_RESEND_EN
            end else if (!retry_q) begin
              retry_d   = 1'b1;
              inh_cnt_d = '0;
              clk_oe_d  = 1'b1;
              state_d   = INHIBIT;
`endif
            end else begin
              error_d = 1'b1;
              state_d = IDLE;
            end
          end
        end else begin
          idle_seen_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A silent device must never leave the bus held; abort wins over any edge this cycle.
    if (timed && (to_cnt_q == TO_MAX)) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      error_d  = 1'b1;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      byte_q      <= '0;
      parity_q    <= 1'b0;
      clk_oe_q    <= 1'b0;
      dat_oe_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      ok_q        <= 1'b0;
      idle_seen_q <= 1'b0;
`ifdef PS2_TX_RESEND_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_q      <= byte_d;
      parity_q    <= parity_d;
      clk_oe_q    <= clk_oe_d;
      dat_oe_q    <= dat_oe_d;
      done_q      <= done_d;
      error_q     <= error_d;
      ok_q        <= ok_d;
      idle_seen_q <= idle_seen_d;
`ifdef PS2_TX_RESEND_EN
      retry_q     <= retry_d;
`endif
    end
  end

  // Completion pulses land in IDLE; holding ready low for that cycle keeps it rising one cycle later.
  assign tx_ready   = (state_q == IDLE) && !done_q && !error_q;
  assign tx_done    = done_q;
  assign tx_error   = error_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model, PS/2 device model and a frame-level reference.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 600;
  localparam int TO  = 2000;
  localparam int H   = 50;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int exp_done = 0, exp_err = 0;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ_HZ    (50000000),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always @(negedge clk) begin
    if (resetn) begin
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (tx_done && tx_error) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wire frame as the device sees it: 8 data bits LSB first, odd parity, stop bit.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    int ones;
    ones = $countones(b);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic send(input logic [7:0] b);
    check("ready_before_send", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~b;
    check("ready_drop_after_accept", tx_ready, 0);
  endtask

  // Device side: wait for request-to-send, then clock nclk bits, sampling data on rising edges.
  task automatic dev_xfer(input int nclk, input bit ack, output logic [9:0] got);
    int n;
    got = '0;
    n = 0;
    while (!ps2_clk_oe && n < INH + 200) begin
      @(negedge clk);
      n++;
    end
    check("rts_seen", ps2_clk_oe, 1);
    if (!ps2_clk_oe) return;
    n = 0;
    while (ps2_clk_oe && n < INH + 100) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_cycles", n, INH);
    check("start_bit_with_clk_release", ps2_dat_oe, 1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < nclk; i++) begin
      if (i == 10 && ack) begin
        dev_dat = 1'b0;
        repeat (10) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      if (i < 10) got[i] = ps2_dat_in;
      dev_clk = 1'b1;
      if (i == 10) dev_dat = 1'b1;
      else repeat (H) @(negedge clk);
    end
  endtask

  task automatic wait_pulse(input string tag, input bit want_done);
    int n;
    n = 0;
    while (!(tx_done || tx_error) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pulse_seen"}, tx_done | tx_error, 1);
    check({tag, "_done"}, tx_done, want_done);
    check({tag, "_error"}, tx_error, !want_done);
    check({tag, "_ready_low_in_pulse"}, tx_ready, 0);
    @(negedge clk);
    check({tag, "_ready_after_pulse"}, tx_ready, 1);
    check({tag, "_pulse_one_cycle"}, tx_done | tx_error, 0);
  endtask

  task automatic full_send(input string tag, input logic [7:0] b);
    logic [9:0] got;
    send(b);
    dev_xfer(11, 1'b1, got);
    check({tag, "_frame"}, got, exp_frame(b));
    wait_pulse(tag, 1'b1);
    exp_done++;
  endtask

  initial begin
    logic [9:0] got;
    logic [7:0] b;
    int n, seen;

    repeat (3) @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    full_send("set_leds", PS2_CMD_SET_LEDS);

    send(8'h01);
    dev_xfer(11, 1'b1, got);
    check("byte01_parity_bit", got[8], 0);
    check("byte01_frame", got, exp_frame(8'h01));
    wait_pulse("byte01", 1'b1);
    exp_done++;

    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom_range(0, 255));
      full_send("random", b);
    end

    b = 8'($urandom_range(0, 255));
    send(b);
    dev_xfer(11, 1'b0, got);
    check("nack_frame", got, exp_frame(b));
`ifdef PS2_TX_RESEND_EN
    dev_xfer(11, 1'b1, got);
    check("resend_frame", got, exp_frame(b));
    wait_pulse("resend", 1'b1);
    exp_done++;
`else
    wait_pulse("nack", 1'b0);
    exp_err++;
`endif

    send(8'($urandom_range(0, 255)));
    dev_xfer(0, 1'b0, got);
    n = 0;
    while (!tx_error && n < TO + 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_error", tx_error, 1);
    check("timeout_clk_oe", ps2_clk_oe, 0);
    check("timeout_dat_oe", ps2_dat_oe, 0);
    check("timeout_window", ((n + 20) >= TO - 2) && ((n + 20) <= TO + 4), 1);
    exp_err++;
    @(negedge clk);
    check("timeout_ready_after", tx_ready, 1);

    send(8'($urandom_range(0, 255)));
    repeat (100) @(negedge clk);
    check("inh_reset_pre_clk_oe", ps2_clk_oe, 1);
    resetn = 1'b0;
    #1;
    check("inh_reset_clk_oe", ps2_clk_oe, 0);
    check("inh_reset_ready", tx_ready, 1);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    b = 8'($urandom_range(0, 255)) & 8'hF7;
    send(b);
    dev_xfer(4, 1'b1, got);
    check("data_reset_first_bits", got[3:0], b[3:0]);
    check("data_reset_pre_dat_oe", ps2_dat_oe, 1);
    resetn = 1'b0;
    #1;
    check("data_reset_clk_oe", ps2_clk_oe, 0);
    check("data_reset_dat_oe", ps2_dat_oe, 0);
    check("data_reset_ready", tx_ready, 1);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    full_send("reset_cmd", PS2_CMD_RESET);

    send(PS2_CMD_SET_LEDS);
    fork
      dev_xfer(11, 1'b1, got);
      begin
        repeat (INH + 300) @(negedge clk);
        check("busy_ready_low", tx_ready, 0);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    check("ignore_frame", got, exp_frame(PS2_CMD_SET_LEDS));
    wait_pulse("ignore", 1'b1);
    exp_done++;
    seen = 0;
    repeat (INH + 100) begin
      @(negedge clk);
      if (ps2_clk_oe) seen = 1;
    end
    check("ignore_no_second_rts", seen, 0);

    check("done_count", done_cnt, exp_done);
    check("error_count", err_cnt, exp_err);
    check("done_error_exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
